// File: rtl/yuv_pkg.sv
// Shared BT.601 constants, FSM state type and clamp helper for the RGB to YUV 4:2:2 stream.
package yuv_pkg;

    localparam int Y_R  = 66;
    localparam int Y_G  = 129;
    localparam int Y_B  = 25;
    localparam int CB_R = -38;
    localparam int CB_G = -74;
    localparam int CB_B = 112;
    localparam int CR_R = 112;
    localparam int CR_G = -94;
    localparam int CR_B = -18;

    localparam int ROUND_ADD = 128;
    localparam int Y_OFFSET  = 16;
    localparam int C_OFFSET  = 128;

    typedef enum logic [1:0] {
        S_EVEN,
        S_ODD,
        S_OUT0,
        S_OUT1
    } state_t;

    // Saturates a signed intermediate into the unsigned range of a dw-bit component.
    function automatic logic [31:0] clamp_unsigned(input logic signed [63:0] value, input int dw);
        logic signed [63:0] max_val;
        max_val = (64'sd1 <<< dw) - 64'sd1;
        if (value < 64'sd0) begin
            return 32'd0;
        end else if (value > max_val) begin
            return max_val[31:0];
        end
        return value[31:0];
    endfunction

endpackage

// File: rtl/rgb_to_ycbcr_px.sv
// Combinational BT.601 converter for one pixel, with floor shift and saturation to DW bits.
module rgb_to_ycbcr_px #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic [DW-1:0] cb,
    output logic [DW-1:0] cr
);
    import yuv_pkg::*;

    localparam int W = 2 * DW + 2;
    localparam int K = DW - 8;

    function automatic logic signed [W-1:0] cw(input int v);
        return W'(v);
    endfunction

    logic signed [W-1:0] rs, gs, bs;
    logic signed [W-1:0] y_acc, cb_acc, cr_acc;

    // Offsets scale with the extra component bits so white/black levels track DW.
    always_comb begin
        rs = W'($signed({1'b0, r}));
        gs = W'($signed({1'b0, g}));
        bs = W'($signed({1'b0, b}));

        y_acc  = ((cw(Y_R) * rs + cw(Y_G) * gs + cw(Y_B) * bs + cw(ROUND_ADD)) >>> 8)
                 + cw(Y_OFFSET << K);
        cb_acc = ((cw(CB_R) * rs + cw(CB_G) * gs + cw(CB_B) * bs + cw(ROUND_ADD)) >>> 8)
                 + cw(C_OFFSET << K);
        cr_acc = ((cw(CR_R) * rs + cw(CR_G) * gs + cw(CR_B) * bs + cw(ROUND_ADD)) >>> 8)
                 + cw(C_OFFSET << K);

        y  = DW'(clamp_unsigned(64'(y_acc), DW));
        cb = DW'(clamp_unsigned(64'(cb_acc), DW));
        cr = DW'(clamp_unsigned(64'(cr_acc), DW));
    end

endmodule

// File: rtl/rgb_to_yuv422_stream.sv
// Streaming RGB to YCbCr 4:2:2: pairs even/odd pixels per line, emits (Cb,Y0) then (Cr,Y1).
module rgb_to_yuv422_stream #(
    parameter int DW         = 8,
    parameter int CHROMA_AVG = 1,
    parameter int AVG_ROUND  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_r,
    input  logic [DW-1:0] s_g,
    input  logic [DW-1:0] s_b,
    input  logic          s_eol,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_y,
    output logic [DW-1:0] m_c,
    output logic          m_c_is_v,
    output logic          m_eol
);
    import yuv_pkg::*;

    localparam logic [DW:0] RND = {{DW{1'b0}}, (AVG_ROUND != 0)};

    state_t        state, next_state;
    logic [DW-1:0] px_y, px_cb, px_cr;
    logic [DW-1:0] y0, cb0, cr0, y1, cb1, cr1;
    logic          eol_q;
    logic [DW:0]   cb_sum, cr_sum;
    logic [DW-1:0] cb_pair, cr_pair;
    logic          take_even, take_odd;

    rgb_to_ycbcr_px #(.DW(DW)) u_px (
        .r  (s_r),
        .g  (s_g),
        .b  (s_b),
        .y  (px_y),
        .cb (px_cb),
        .cr (px_cr)
    );

    always_comb begin
        cb_sum  = {1'b0, cb0} + {1'b0, cb1} + RND;
        cr_sum  = {1'b0, cr0} + {1'b0, cr1} + RND;
        cb_pair = (CHROMA_AVG != 0) ? DW'(cb_sum >> 1) : cb0;
        cr_pair = (CHROMA_AVG != 0) ? DW'(cr_sum >> 1) : cr0;
    end

    // S_OUT1 doubles as an even-pixel accept slot so a pair costs three cycles.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_y        = '0;
        m_c        = '0;
        m_c_is_v   = 1'b0;
        m_eol      = 1'b0;
        case (state)
            S_EVEN: begin
                s_ready = 1'b1;
                if (s_valid) next_state = s_eol ? S_OUT0 : S_ODD;
            end
            S_ODD: begin
                s_ready = 1'b1;
                if (s_valid) next_state = S_OUT0;
            end
            S_OUT0: begin
                m_valid = 1'b1;
                m_y     = y0;
                m_c     = cb_pair;
                if (m_ready) next_state = S_OUT1;
            end
            S_OUT1: begin
                m_valid  = 1'b1;
                m_y      = y1;
                m_c      = cr_pair;
                m_c_is_v = 1'b1;
                m_eol    = eol_q;
                s_ready  = m_ready;
                if (m_ready) begin
                    if (s_valid) next_state = s_eol ? S_OUT0 : S_ODD;
                    else         next_state = S_EVEN;
                end
            end
            default: next_state = S_EVEN;
        endcase
        if (rst) begin
            s_ready  = 1'b0;
            m_valid  = 1'b0;
            m_y      = '0;
            m_c      = '0;
            m_c_is_v = 1'b0;
            m_eol    = 1'b0;
        end
        take_even = s_valid && s_ready && ((state == S_EVEN) || (state == S_OUT1));
        take_odd  = s_valid && s_ready && (state == S_ODD);
    end

    // An even pixel also fills the odd slot, so a line-ending single pixel pads itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EVEN;
            y0    <= '0;
            cb0   <= '0;
            cr0   <= '0;
            y1    <= '0;
            cb1   <= '0;
            cr1   <= '0;
            eol_q <= 1'b0;
        end else begin
            state <= next_state;
            if (take_even) begin
                y0    <= px_y;
                cb0   <= px_cb;
                cr0   <= px_cr;
                y1    <= px_y;
                cb1   <= px_cb;
                cr1   <= px_cr;
                eol_q <= s_eol;
            end else if (take_odd) begin
                y1    <= px_y;
                cb1   <= px_cb;
                cr1   <= px_cr;
                eol_q <= s_eol;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv422_stream.sv
// Self-checking bench: averaging, decimating and 10-bit instances driven in lock-step.
module tb_rgb_to_yuv422_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s_valid, s_eol, m_ready;
    logic [7:0] s_r, s_g, s_b;
    logic [9:0] x_r, x_g, x_b;

    logic       a_s_ready, a_m_valid, a_m_c_is_v, a_m_eol;
    logic [7:0] a_m_y, a_m_c;
    logic       d_s_ready, d_m_valid, d_m_c_is_v, d_m_eol;
    logic [7:0] d_m_y, d_m_c;
    logic       w_s_ready, w_m_valid, w_m_c_is_v, w_m_eol;
    logic [9:0] w_m_y, w_m_c;

    rgb_to_yuv422_stream #(.DW(8), .CHROMA_AVG(1), .AVG_ROUND(1)) u_avg (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_eol(s_eol),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_y(a_m_y), .m_c(a_m_c),
        .m_c_is_v(a_m_c_is_v), .m_eol(a_m_eol)
    );

    rgb_to_yuv422_stream #(.DW(8), .CHROMA_AVG(0), .AVG_ROUND(1)) u_dec (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(d_s_ready),
        .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_eol(s_eol),
        .m_valid(d_m_valid), .m_ready(m_ready), .m_y(d_m_y), .m_c(d_m_c),
        .m_c_is_v(d_m_c_is_v), .m_eol(d_m_eol)
    );

    rgb_to_yuv422_stream #(.DW(10), .CHROMA_AVG(1), .AVG_ROUND(1)) u_w10 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(w_s_ready),
        .s_r(x_r), .s_g(x_g), .s_b(x_b), .s_eol(s_eol),
        .m_valid(w_m_valid), .m_ready(m_ready), .m_y(w_m_y), .m_c(w_m_c),
        .m_c_is_v(w_m_c_is_v), .m_eol(w_m_eol)
    );

    typedef struct {
        int y;
        int c;
        int v;
        int e;
    } beat_t;

    typedef struct {
        logic [7:0] r, g, b;
        logic [9:0] xr, xg, xb;
    } pix_t;

    typedef struct {
        logic [7:0] r0, g0, b0, r1, g1, b1;
        int cb_avg, y0, cr_avg, y1, cb_dec, cr_dec;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    beat_t got_a, got_d, got_w;
    beat_t qa[$], qd[$], qw[$];
    vec_t  vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int conv(input int dw, input int r, input int g, input int b, input int sel);
        int acc, offs, maxv;
        if (sel == 0)      acc = 66 * r + 129 * g + 25 * b;
        else if (sel == 1) acc = -38 * r - 74 * g + 112 * b;
        else               acc = 112 * r - 94 * g - 18 * b;
        offs = ((sel == 0) ? 16 : 128) << (dw - 8);
        acc  = ((acc + 128) >>> 8) + offs;
        maxv = (1 << dw) - 1;
        if (acc < 0)    acc = 0;
        if (acc > maxv) acc = maxv;
        return acc;
    endfunction

    function automatic logic [9:0] x10(input logic [7:0] v);
        return {v, v[7:6]};
    endfunction

    function automatic pix_t mkpix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pix_t p;
        p.r = r; p.g = g; p.b = b;
        p.xr = x10(r); p.xg = x10(g); p.xb = x10(b);
        return p;
    endfunction

    // Expected beats of one output pair for all three instances; a padded pixel is passed as its own partner.
    task automatic pushPair(input pix_t p0, input pix_t p1, input bit eol);
        int ay0, ay1, acb0, acb1, acr0, acr1;
        int wy0, wy1, wcb0, wcb1, wcr0, wcr1;
        ay0  = conv(8, p0.r, p0.g, p0.b, 0);   ay1  = conv(8, p1.r, p1.g, p1.b, 0);
        acb0 = conv(8, p0.r, p0.g, p0.b, 1);   acb1 = conv(8, p1.r, p1.g, p1.b, 1);
        acr0 = conv(8, p0.r, p0.g, p0.b, 2);   acr1 = conv(8, p1.r, p1.g, p1.b, 2);
        wy0  = conv(10, p0.xr, p0.xg, p0.xb, 0); wy1  = conv(10, p1.xr, p1.xg, p1.xb, 0);
        wcb0 = conv(10, p0.xr, p0.xg, p0.xb, 1); wcb1 = conv(10, p1.xr, p1.xg, p1.xb, 1);
        wcr0 = conv(10, p0.xr, p0.xg, p0.xb, 2); wcr1 = conv(10, p1.xr, p1.xg, p1.xb, 2);
        qa.push_back('{ay0, (acb0 + acb1 + 1) >> 1, 0, 0});
        qa.push_back('{ay1, (acr0 + acr1 + 1) >> 1, 1, int'(eol)});
        qd.push_back('{ay0, acb0, 0, 0});
        qd.push_back('{ay1, acr0, 1, int'(eol)});
        qw.push_back('{wy0, (wcb0 + wcb1 + 1) >> 1, 0, 0});
        qw.push_back('{wy1, (wcr0 + wcr1 + 1) >> 1, 1, int'(eol)});
    endtask

    task automatic applyStimulus(input pix_t p, input logic eol);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_r = p.r; s_g = p.g; s_b = p.b;
        x_r = p.xr; x_g = p.xg; x_b = p.xb;
        s_eol = eol;
        while (!a_s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_s_ready) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic takeBeat;
        int n = 0;
        @(negedge clk);
        while (!a_m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_m_valid) begin
            checkOutput("beat_timeout", 0, 1);
            got_a = '{-1, -1, -1, -1};
            got_d = '{-1, -1, -1, -1};
            got_w = '{-1, -1, -1, -1};
            return;
        end
        got_a = '{int'(a_m_y), int'(a_m_c), int'(a_m_c_is_v), int'(a_m_eol)};
        got_d = '{int'(d_m_y), int'(d_m_c), int'(d_m_c_is_v), int'(d_m_eol)};
        got_w = '{int'(w_m_y), int'(w_m_c), int'(w_m_c_is_v), int'(w_m_eol)};
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    // Pops the modelled pair and compares both beats of every instance.
    task automatic checkPair(input string tag);
        beat_t ea, ed, ew;
        for (int k = 0; k < 2; k++) begin
            takeBeat();
            ea = qa.pop_front(); ed = qd.pop_front(); ew = qw.pop_front();
            checkOutput({tag, "_a_y"}, got_a.y, ea.y);
            checkOutput({tag, "_a_c"}, got_a.c, ea.c);
            checkOutput({tag, "_a_v"}, got_a.v, ea.v);
            checkOutput({tag, "_a_eol"}, got_a.e, ea.e);
            checkOutput({tag, "_d_c"}, got_d.c, ed.c);
            checkOutput({tag, "_w_y"}, got_w.y, ew.y);
            checkOutput({tag, "_w_c"}, got_w.c, ew.c);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_m_valid"}, a_m_valid, 0);
        checkOutput({tag, "_m_y"}, a_m_y, 0);
        checkOutput({tag, "_m_c"}, a_m_c, 0);
        checkOutput({tag, "_m_c_is_v"}, a_m_c_is_v, 0);
        checkOutput({tag, "_m_eol"}, a_m_eol, 0);
        checkOutput({tag, "_s_ready"}, a_s_ready, 0);
    endtask

    pix_t red, blue, green, white, black;

    initial begin
        red   = mkpix(8'd255, 8'd0, 8'd0);
        blue  = mkpix(8'd0, 8'd0, 8'd255);
        green = mkpix(8'd0, 8'd255, 8'd0);
        white = mkpix(8'd255, 8'd255, 8'd255);
        black = mkpix(8'd0, 8'd0, 8'd0);

        vecs[0] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 128, 235, 128, 16, 128, 128};
        vecs[1] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 165, 82, 175, 41, 90, 240};
        vecs[2] = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 91, 144, 81, 235, 54, 34};
        vecs[3] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 165, 41, 175, 82, 240, 110};

        rst = 1'b1; s_valid = 1'b0; s_eol = 1'b0; m_ready = 1'b0;
        s_r = '0; s_g = '0; s_b = '0; x_r = '0; x_g = '0; x_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("por_s_ready_after", a_s_ready, 1);

        // Directed pairs with hand-computed beats.
        for (int v = 0; v < 4; v++) begin
            pix_t p0, p1;
            int wy0, wcb, wy1, wcr;
            p0 = mkpix(vecs[v].r0, vecs[v].g0, vecs[v].b0);
            p1 = mkpix(vecs[v].r1, vecs[v].g1, vecs[v].b1);
            wy0 = conv(10, p0.xr, p0.xg, p0.xb, 0);
            wy1 = conv(10, p1.xr, p1.xg, p1.xb, 0);
            wcb = (conv(10, p0.xr, p0.xg, p0.xb, 1) + conv(10, p1.xr, p1.xg, p1.xb, 1) + 1) >> 1;
            wcr = (conv(10, p0.xr, p0.xg, p0.xb, 2) + conv(10, p1.xr, p1.xg, p1.xb, 2) + 1) >> 1;
            applyStimulus(p0, 1'b0);
            applyStimulus(p1, 1'b1);
            takeBeat();
            checkOutput($sformatf("vec%0d_b0_y", v), got_a.y, vecs[v].y0);
            checkOutput($sformatf("vec%0d_b0_cb", v), got_a.c, vecs[v].cb_avg);
            checkOutput($sformatf("vec%0d_b0_is_v", v), got_a.v, 0);
            checkOutput($sformatf("vec%0d_b0_eol", v), got_a.e, 0);
            checkOutput($sformatf("vec%0d_b0_dec_y", v), got_d.y, vecs[v].y0);
            checkOutput($sformatf("vec%0d_b0_dec_cb", v), got_d.c, vecs[v].cb_dec);
            checkOutput($sformatf("vec%0d_b0_w_y", v), got_w.y, wy0);
            checkOutput($sformatf("vec%0d_b0_w_cb", v), got_w.c, wcb);
            if (v == 0) begin
                checkOutput("w10_white_y", got_w.y, 943);
                checkOutput("w10_white_cb", got_w.c, 512);
            end
            takeBeat();
            checkOutput($sformatf("vec%0d_b1_y", v), got_a.y, vecs[v].y1);
            checkOutput($sformatf("vec%0d_b1_cr", v), got_a.c, vecs[v].cr_avg);
            checkOutput($sformatf("vec%0d_b1_is_v", v), got_a.v, 1);
            checkOutput($sformatf("vec%0d_b1_eol", v), got_a.e, 1);
            checkOutput($sformatf("vec%0d_b1_dec_cr", v), got_d.c, vecs[v].cr_dec);
            checkOutput($sformatf("vec%0d_b1_w_y", v), got_w.y, wy1);
            checkOutput($sformatf("vec%0d_b1_w_cr", v), got_w.c, wcr);
        end

        // Odd-length line of three reds, then a lone blue that must not reuse the stale odd slot.
        applyStimulus(red, 1'b0);
        applyStimulus(red, 1'b0);
        pushPair(red, red, 1'b0);
        checkPair("odd_pair");
        applyStimulus(red, 1'b1);
        pushPair(red, red, 1'b1);
        checkPair("odd_pad");
        applyStimulus(blue, 1'b1);
        takeBeat();
        checkOutput("lone_blue_b0_y", got_a.y, 41);
        checkOutput("lone_blue_b0_cb", got_a.c, 240);
        takeBeat();
        checkOutput("lone_blue_b1_y", got_a.y, 41);
        checkOutput("lone_blue_b1_cr", got_a.c, 110);
        checkOutput("lone_blue_b1_eol", got_a.e, 1);

        // Backpressure: outputs hold in both beats and no input is taken in S_OUT0.
        applyStimulus(red, 1'b0);
        applyStimulus(blue, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp0_valid", a_m_valid, 1);
            checkOutput("bp0_y", a_m_y, 82);
            checkOutput("bp0_c", a_m_c, 165);
            checkOutput("bp0_s_ready", a_s_ready, 0);
        end
        takeBeat();
        checkOutput("bp0_taken_c", got_a.c, 165);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp1_valid", a_m_valid, 1);
            checkOutput("bp1_y", a_m_y, 41);
            checkOutput("bp1_c", a_m_c, 175);
            checkOutput("bp1_is_v", a_m_c_is_v, 1);
        end
        takeBeat();
        checkOutput("bp1_taken_c", got_a.c, 175);
        @(negedge clk);
        checkOutput("bp_no_dup_beat", a_m_valid, 0);

        // Reset while waiting for the odd pixel discards the half pair.
        applyStimulus(red, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("rst_odd");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_odd_s_ready", a_s_ready, 1);
        applyStimulus(green, 1'b0);
        applyStimulus(white, 1'b1);
        pushPair(green, white, 1'b1);
        checkPair("rst_odd_after");

        // Reset during the Cr beat.
        applyStimulus(blue, 1'b0);
        applyStimulus(red, 1'b1);
        takeBeat();
        checkOutput("rst_out1_pre_cb", got_a.c, 165);
        @(negedge clk);
        checkOutput("rst_out1_in_out1", a_m_c_is_v, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("rst_out1");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(white, 1'b0);
        applyStimulus(black, 1'b1);
        pushPair(white, black, 1'b1);
        checkPair("rst_out1_after");

        // Random stream with random backpressure against the pairing model.
        begin
            int   sent = 0;
            int   cyc = 0;
            bit   acc = 0;
            bit   have_even = 0;
            bit   hold = 0;
            int   hy = 0, hc = 0;
            pix_t pe, pn;
            beat_t ea, ed, ew;
            while ((sent < 64 || s_valid || qa.size() > 0) && cyc < 4000) begin
                @(posedge clk);
                #1;
                cyc++;
                if (acc) s_valid = 1'b0;
                if (!s_valid && sent < 64 && $urandom_range(0, 3) != 0) begin
                    pn = mkpix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                               8'($urandom_range(0, 255)));
                    pn.xr = 10'($urandom_range(0, 1023));
                    pn.xg = 10'($urandom_range(0, 1023));
                    pn.xb = 10'($urandom_range(0, 1023));
                    s_eol = (sent == 63) || ($urandom_range(0, 6) == 0);
                    if (!have_even) begin
                        if (s_eol) pushPair(pn, pn, 1'b1);
                        else begin
                            pe = pn;
                            have_even = 1;
                        end
                    end else begin
                        pushPair(pe, pn, s_eol);
                        have_even = 0;
                    end
                    s_r = pn.r; s_g = pn.g; s_b = pn.b;
                    x_r = pn.xr; x_g = pn.xg; x_b = pn.xb;
                    s_valid = 1'b1;
                    sent++;
                end
                m_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (hold) begin
                    checkOutput("stream_hold_valid", a_m_valid, 1);
                    checkOutput("stream_hold_y", a_m_y, hy);
                    checkOutput("stream_hold_c", a_m_c, hc);
                end
                hold = a_m_valid && !m_ready;
                hy = int'(a_m_y);
                hc = int'(a_m_c);
                if (a_m_valid && m_ready) begin
                    if (qa.size() == 0) begin
                        checkOutput("stream_unexpected_beat", 1, 0);
                    end else begin
                        ea = qa.pop_front(); ed = qd.pop_front(); ew = qw.pop_front();
                        checkOutput("stream_a_y", a_m_y, ea.y);
                        checkOutput("stream_a_c", a_m_c, ea.c);
                        checkOutput("stream_a_v", a_m_c_is_v, ea.v);
                        checkOutput("stream_a_eol", a_m_eol, ea.e);
                        checkOutput("stream_d_y", d_m_y, ed.y);
                        checkOutput("stream_d_c", d_m_c, ed.c);
                        checkOutput("stream_w_y", w_m_y, ew.y);
                        checkOutput("stream_w_c", w_m_c, ew.c);
                    end
                end
                acc = s_valid && a_s_ready;
            end
            checkOutput("stream_drained", qa.size(), 0);
            checkOutput("stream_all_sent", sent, 64);
            m_ready = 1'b0;
            s_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
